// File: rtl/multdiv_stall_ctrl_if.sv
// Handshake bundle between the execute stage, the iterative multdiv unit and
// the multdiv stall controller.
interface multdiv_stall_ctrl_if;
    logic        x_valid;
    logic        x_is_multdiv;
    logic        x_is_div;
    logic [31:0] x_opA;
    logic [31:0] x_opB;
    logic [4:0]  x_rd;
    logic [31:0] x_status_code;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_opA;
    logic [31:0] md_opB;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output x_valid, x_is_multdiv, x_is_div, x_opA, x_opB, x_rd, x_status_code,
        output md_result, md_exception, md_ready,
        input  md_ctrl_mult, md_ctrl_div, md_opA, md_opB, stall, busy,
        input  wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  x_valid, x_is_multdiv, x_is_div, x_opA, x_opB, x_rd, x_status_code,
        input  md_result, md_exception, md_ready,
        output md_ctrl_mult, md_ctrl_div, md_opA, md_opB, stall, busy,
        output wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/multdiv_stall_ctrl.sv
// Execute-stage controller: freezes the pipeline while the iterative multdiv
// unit runs, then emits a single writeback of the result or the status code.
module multdiv_stall_ctrl #(
    parameter int TIMEOUT     = 40,
    parameter int CNT_W       = 6,
    parameter int RSTATUS_REG = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_stall_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [4:0]       RS_IDX   = 5'(RSTATUS_REG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              div_r, div_nxt_s;
    logic [4:0]        rd_r, rd_nxt_s;
    logic [31:0]       code_r, code_nxt_s;
    logic [31:0]       result_r, result_nxt_s;
    logic              exc_r, exc_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [31:0]       opa_r, opa_nxt_s;
    logic [31:0]       opb_r, opb_nxt_s;
    logic              ctrl_mult_r, ctrl_mult_nxt_s;
    logic              ctrl_div_r, ctrl_div_nxt_s;
    logic              wb_valid_r, wb_valid_nxt_s;
    logic [4:0]        wb_rd_r, wb_rd_nxt_s;
    logic [31:0]       wb_data_r, wb_data_nxt_s;
    logic              trig_s;
    logic              first_run_s;
    logic              finish_s;
    logic              stall_s;

    // The start pulse is high exactly in the first RUN cycle, so it doubles as
    // the "ignore md_ready" marker.
    assign trig_s      = bus.x_valid & bus.x_is_multdiv;
    assign first_run_s = ctrl_mult_r | ctrl_div_r;

    // Next-state, latch updates and the combinational stall request.
    always_comb begin
        state_nxt_s     = state_r;
        div_nxt_s       = div_r;
        rd_nxt_s        = rd_r;
        code_nxt_s      = code_r;
        result_nxt_s    = result_r;
        exc_nxt_s       = exc_r;
        cnt_nxt_s       = cnt_r;
        opa_nxt_s       = opa_r;
        opb_nxt_s       = opb_r;
        ctrl_mult_nxt_s = 1'b0;
        ctrl_div_nxt_s  = 1'b0;
        wb_valid_nxt_s  = 1'b0;
        wb_rd_nxt_s     = 5'd0;
        wb_data_nxt_s   = 32'd0;
        finish_s        = 1'b0;
        stall_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall_s = trig_s;
                if (trig_s) begin
                    opa_nxt_s       = bus.x_opA;
                    opb_nxt_s       = bus.x_opB;
                    rd_nxt_s        = bus.x_rd;
                    div_nxt_s       = bus.x_is_div;
                    code_nxt_s      = bus.x_status_code;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    ctrl_mult_nxt_s = ~bus.x_is_div;
                    ctrl_div_nxt_s  = bus.x_is_div;
                    state_nxt_s     = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                stall_s   = 1'b1;
                cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (bus.md_ready && !first_run_s) begin
                    result_nxt_s = bus.md_result;
                    exc_nxt_s    = bus.md_exception;
                    finish_s     = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    exc_nxt_s = 1'b1;
                    finish_s  = 1'b1;
                end else begin
                    finish_s = 1'b0;
                end
                if (finish_s) begin
                    state_nxt_s = ST_DONE;
                    // Non-exception writes to r0 are dropped entirely.
                    wb_valid_nxt_s = exc_nxt_s | (rd_r != 5'd0);
                    if (!wb_valid_nxt_s) begin
                        wb_rd_nxt_s   = 5'd0;
                        wb_data_nxt_s = 32'd0;
                    end else if (exc_nxt_s) begin
                        wb_rd_nxt_s   = RS_IDX;
                        wb_data_nxt_s = code_r;
                    end else begin
                        wb_rd_nxt_s   = rd_r;
                        wb_data_nxt_s = result_nxt_s;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            div_r       <= 1'b0;
            rd_r        <= 5'd0;
            code_r      <= 32'd0;
            result_r    <= 32'd0;
            exc_r       <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            opa_r       <= 32'd0;
            opb_r       <= 32'd0;
            ctrl_mult_r <= 1'b0;
            ctrl_div_r  <= 1'b0;
            wb_valid_r  <= 1'b0;
            wb_rd_r     <= 5'd0;
            wb_data_r   <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            div_r       <= div_nxt_s;
            rd_r        <= rd_nxt_s;
            code_r      <= code_nxt_s;
            result_r    <= result_nxt_s;
            exc_r       <= exc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            opa_r       <= opa_nxt_s;
            opb_r       <= opb_nxt_s;
            ctrl_mult_r <= ctrl_mult_nxt_s;
            ctrl_div_r  <= ctrl_div_nxt_s;
            wb_valid_r  <= wb_valid_nxt_s;
            wb_rd_r     <= wb_rd_nxt_s;
            wb_data_r   <= wb_data_nxt_s;
        end
    end

    assign bus.md_ctrl_mult = ctrl_mult_r;
    assign bus.md_ctrl_div  = ctrl_div_r;
    assign bus.md_opA       = opa_r;
    assign bus.md_opB       = opb_r;
    assign bus.stall        = stall_s;
    assign bus.busy         = (state_r != ST_IDLE);
    assign bus.wb_valid     = wb_valid_r;
    assign bus.wb_rd        = wb_rd_r;
    assign bus.wb_data      = wb_data_r;
endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Directed bench for multdiv_stall_ctrl: per-cycle checks of stall, start
// pulses, operand hold and the single writeback for hand-built scenarios.
module tb_multdiv_stall_ctrl;
    localparam int TIMEOUT = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks_cnt = 0;
    int   errors_cnt = 0;

    multdiv_stall_ctrl_if bus();

    multdiv_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6), .RSTATUS_REG(30)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.x_valid       = 1'b0;
        bus.x_is_multdiv  = 1'b0;
        bus.x_is_div      = 1'b0;
        bus.x_opA         = 32'd0;
        bus.x_opB         = 32'd0;
        bus.x_rd          = 5'd0;
        bus.x_status_code = 32'd0;
        bus.md_result     = 32'd0;
        bus.md_exception  = 1'b0;
        bus.md_ready      = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
        check_eq({tag, "_mult"},  {31'd0, bus.md_ctrl_mult}, 32'd0);
        check_eq({tag, "_div"},   {31'd0, bus.md_ctrl_div}, 32'd0);
        check_eq({tag, "_wbv"},   {31'd0, bus.wb_valid}, 32'd0);
        check_eq({tag, "_wbrd"},  {27'd0, bus.wb_rd}, 32'd0);
        check_eq({tag, "_wbd"},   bus.wb_data, 32'd0);
    endtask

    // One mult/div from trigger (cycle 0) to DONE. rdy_cyc < 0 means md_ready never
    // comes; early_rdy pulses md_ready (with exception) in cycles 0 and 1.
    task automatic run_op(input string tag, input logic is_div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] code,
                          input int rdy_cyc, input logic [31:0] res, input logic exc,
                          input logic early_rdy);
        int          end_cyc;
        logic        exp_exc;
        logic        exp_wbv;
        end_cyc = (rdy_cyc < 0) ? TIMEOUT + 1 : rdy_cyc + 1;
        exp_exc = (rdy_cyc < 0) ? 1'b1 : exc;
        exp_wbv = exp_exc | (rd != 5'd0);
        for (int c = 0; c <= end_cyc; c++) begin
            @(negedge clock);
            bus.x_valid       = 1'b1;
            bus.x_is_multdiv  = 1'b1;
            bus.x_is_div      = is_div;
            bus.x_opA         = a;
            bus.x_opB         = b;
            bus.x_rd          = rd;
            bus.x_status_code = code;
            bus.md_ready      = (c == rdy_cyc) || (early_rdy && c <= 1);
            bus.md_result     = (c == rdy_cyc) ? res : 32'hDEAD_BEEF;
            bus.md_exception  = (c == rdy_cyc) ? exc : 1'b1;
            #1;
            check_eq({tag, "_stall"}, {31'd0, bus.stall}, {31'd0, c < end_cyc});
            check_eq({tag, "_busy"},  {31'd0, bus.busy}, {31'd0, c >= 1});
            check_eq({tag, "_mult"},  {31'd0, bus.md_ctrl_mult}, {31'd0, c == 1 && !is_div});
            check_eq({tag, "_div"},   {31'd0, bus.md_ctrl_div}, {31'd0, c == 1 && is_div});
            check_eq({tag, "_wbv"},   {31'd0, bus.wb_valid}, {31'd0, c == end_cyc && exp_wbv});
            if (c == end_cyc && exp_wbv) begin
                check_eq({tag, "_wbrd"}, {27'd0, bus.wb_rd}, exp_exc ? 32'd30 : {27'd0, rd});
                check_eq({tag, "_wbd"},  bus.wb_data, exp_exc ? code : res);
            end else begin
                check_eq({tag, "_wbrd"}, {27'd0, bus.wb_rd}, 32'd0);
                check_eq({tag, "_wbd"},  bus.wb_data, 32'd0);
            end
            if (c >= 1 && c < end_cyc) begin
                check_eq({tag, "_opA"}, bus.md_opA, a);
                check_eq({tag, "_opB"}, bus.md_opB, b);
            end
        end
    endtask

    initial begin
        drive_idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_quiet("reset");
        check_eq("reset_opA", bus.md_opA, 32'd0);

        // Mult, no exception, with a stray md_ready in IDLE/first RUN cycle.
        run_op("mult", 1'b0, 32'd7, 32'd6, 5'd5, 32'd4, 17, 32'd42, 1'b0, 1'b1);
        @(negedge clock); drive_idle(); #1; check_quiet("mult_idle");

        run_op("divz", 1'b1, 32'd9, 32'd0, 5'd3, 32'd5, 34, 32'd0, 1'b1, 1'b0);
        @(negedge clock); drive_idle(); #1; check_quiet("divz_idle");

        run_op("ovf", 1'b0, 32'h4000_0000, 32'd4, 5'd8, 32'd4, 6, 32'd0, 1'b1, 1'b0);
        @(negedge clock); drive_idle(); #1; check_quiet("ovf_idle");

        // Timeout with md_ready only in IDLE and the first RUN cycle.
        run_op("tmo", 1'b1, 32'd100, 32'd7, 5'd9, 32'h0000_0005, -1, 32'd0, 1'b0, 1'b1);
        @(negedge clock); drive_idle(); #1; check_quiet("tmo_idle");

        // rd=0 suppression, immediately followed by a second mult held in X.
        run_op("rd0", 1'b0, 32'd3, 32'd3, 5'd0, 32'd4, 3, 32'd9, 1'b0, 1'b0);
        run_op("b2b", 1'b0, 32'd1, 32'd3, 5'd7, 32'd4, 2, 32'd3, 1'b0, 1'b0);
        @(negedge clock); drive_idle(); #1; check_quiet("b2b_idle");

        // Reset during RUN (cycle 10), then a late md_ready must be dropped.
        for (int c = 0; c <= 10; c++) begin
            @(negedge clock);
            bus.x_valid      = 1'b1;
            bus.x_is_multdiv = 1'b1;
            bus.x_is_div     = 1'b0;
            bus.x_opA        = 32'd11;
            bus.x_opB        = 32'd12;
            bus.x_rd         = 5'd4;
            reset            = (c == 10);
        end
        @(negedge clock);
        reset = 1'b0;
        drive_idle();
        #1;
        check_quiet("rst_mid");
        check_eq("rst_mid_opA", bus.md_opA, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            bus.md_ready  = 1'b1;
            bus.md_result = 32'd132;
            #1;
            check_quiet("rst_late");
        end
        @(negedge clock);
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule

// File: doc/multdiv_stall_ctrl.md
Name: multdiv_stall_ctrl

Overview:
Execute-stage controller for multi-cycle mult/div instructions.
- Sits between decode/execute and the iterative multdiv unit.
- Consumes the 32-bit $rstatus code produced by the rstatus status-code stage.
- On a mult/div it freezes F/D/X, drives the multdiv start pulse, and waits for ready or a timeout.
- Then emits one writeback: the result to rd, or the status code to $r30 on exception.

Parameters:
TIMEOUT, 40, RUN cycles after the start pulse before a forced exception; must be ≥3.
CNT_W, 6, cycle-counter width; 2^CNT_W > TIMEOUT.
RSTATUS_REG, 30, register index that receives exception status codes.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
x_valid  in  1  execute stage holds a valid instruction
x_is_multdiv  in  1  decoded R-type mult or div (alu_op 00110/00111)
x_is_div  in  1  1=div, 0=mult; meaningful only with x_is_multdiv
x_opA  in  32  operand A
x_opB  in  32  operand B
x_rd  in  5  destination register
x_status_code  in  32  rstatus code from status-code stage (mult=4, div=5)
md_result  in  32  multdiv result
md_exception  in  1  multdiv overflow / divide-by-zero; valid with md_ready
md_ready  in  1  multdiv result valid
md_ctrl_mult  out  1  one-cycle mult start pulse
md_ctrl_div  out  1  one-cycle div start pulse
md_opA  out  32  latched operand A, held through RUN
md_opB  out  32  latched operand B, held through RUN
stall  out  1  freeze F/D/X pipeline registers
busy  out  1  controller not in IDLE
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback register
wb_data  out  32  writeback data

Behaviour:
Reset and clocking
- Clock and reset: single clock. Synchronous active-high reset on the rising edge of clock.
- Reset values: state=IDLE; all outputs 0; internal latches (op type, rd, code, result, exc flag, counter) 0.
- Reset mid-operation: return to IDLE; drop any pending result; emit no writeback.

State machine: IDLE, RUN, DONE.

IDLE
- trig = x_valid & x_is_multdiv.
- stall = trig, combinational, so the instruction holds in X.
- On trig:
  - latch opA, opB, rd, x_is_div, x_status_code;
  - cnt<=0;
  - next state RUN.
- md_ready and md_exception are ignored in IDLE.

RUN
- First RUN cycle: md_ctrl_mult = ~div_l and md_ctrl_div = div_l, both registered; high for exactly this cycle.
- md_ready is ignored in the first RUN cycle.
- Every RUN cycle: stall=1, busy=1, md_opA/md_opB hold the latched values, cnt increments.
- md_ready=1, from the second RUN cycle on:
  - latch md_result and exc = md_exception;
  - next state DONE.
- Timeout: if cnt==TIMEOUT-1 with no accepted md_ready, latch exc=1 and go to DONE.
- md_ready and timeout in the same cycle: md_ready wins, and its md_exception is used.

DONE, exactly one cycle
- stall=0, so the instruction advances. busy=1.
- wb_valid = ~(~exc & rd_l==0). A non-exception write to r0 is suppressed.
- Exception: wb_rd=RSTATUS_REG, wb_data=code_l. Otherwise: wb_rd=rd_l, wb_data=result_l.
- x_is_multdiv is ignored this cycle, because it still reflects the same instruction.
- Next state IDLE.
- wb_rd/wb_data return to 0 when wb_valid=0.

Timing and ordering
- Latency: detect at cycle 0, start pulse at cycle 1. If md_ready arrives at cycle N≥2, wb_valid is at N+1 and stall drops at N+1.
- Back-to-back: a new mult/div can trigger in the first IDLE cycle after DONE.
- x_status_code is used as delivered. No remapping or width change; 32 bits pass through.

Test Plan:
- Mult, no exception: mult with opA=7, opB=6, rd=5, md_ready at cycle 17 with result 42 -> md_ctrl_mult pulse at cycle 1 only; stall high cycles 0–17; cycle 18 wb_valid=1, wb_rd=5, wb_data=42, stall=0.
- Divide by zero: div with opB=0, code=5, md_ready at cycle 34 with md_exception=1 -> md_ctrl_div pulse at cycle 1; cycle 35 wb_rd=30, wb_data=5.
- Mult overflow: 0x40000000*4, code=4, md_exception=1 -> wb_rd=30, wb_data=4; md_opA/md_opB remain stable throughout RUN.
- Timeout: md_ready never asserted, TIMEOUT=40 -> DONE at cycle 41 with wb_rd=30, wb_data=code. md_ready asserted only during the first RUN cycle or in IDLE -> ignored.
- rd=0, and back-to-back: mult rd=0, no exception -> wb_valid stays 0, stall releases normally. A second mult held in X right after DONE -> triggers the cycle after DONE, not during DONE.
- Reset mid-RUN (cycle 10) -> next cycle state IDLE, all outputs 0; a subsequent md_ready produces no writeback.
